// File: rtl/if_bpu_pkg.sv
//------------------------------------------------------------------------------
// if_bpu_pkg : counter encodings, saturating update and default BPU geometry
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package if_bpu_pkg;

   typedef enum logic [1:0] {
      SNT = 2'd0,
      WNT = 2'd1,
      WT  = 2'd2,
      ST  = 2'd3
   } ctr_t;

   localparam int XLEN_DFLT        = 32;
   localparam int BTB_ENTRIES_DFLT = 16;
   localparam int BHT_ENTRIES_DFLT = 64;
   localparam int GHR_BITS_DFLT    = 6;
   localparam int BTB_IDX_W        = $clog2(BTB_ENTRIES_DFLT);
   localparam int BHT_IDX_W        = $clog2(BHT_ENTRIES_DFLT);
   localparam int BTB_TAG_W        = XLEN_DFLT - 2 - BTB_IDX_W;

   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      if (taken) begin
         if (c != ST) n = ctr_t'(c + 2'd1);
      end else begin
         if (c != SNT) n = ctr_t'(c - 2'd1);
      end
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/if_btb.sv
//------------------------------------------------------------------------------
// if_btb : direct-mapped branch target buffer, async read, sync write
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_btb #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES),
   parameter int TAG_W   = XLEN - 2 - IDX_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             rd_hit,
   output logic [XLEN-1:0]  rd_target,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [XLEN-1:0]  wr_target
);

   logic             valid_q  [ENTRIES];
   logic             valid_d  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [TAG_W-1:0] tag_d    [ENTRIES];
   logic [XLEN-1:0]  target_q [ENTRIES];
   logic [XLEN-1:0]  target_d [ENTRIES];

   assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_target = target_q[rd_idx];

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (wr_en) begin
         valid_d[wr_idx]  = 1'b1;
         tag_d[wr_idx]    = wr_tag;
         target_d[wr_idx] = wr_target;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag/target payload is qualified by valid, so it needs no reset.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
   end

endmodule

`default_nettype wire

// File: rtl/if_fetch_btb.sv
//------------------------------------------------------------------------------
// if_fetch_btb : fetch PC with same-cycle BTB + 2-bit counter prediction and
//                EX-driven repair. Define GSHARE_EN for gshare-indexed counters.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_btb
   import if_bpu_pkg::*;
#(
   parameter int              XLEN        = XLEN_DFLT,
   parameter int              BTB_ENTRIES = BTB_ENTRIES_DFLT,
   parameter int              BHT_ENTRIES = BHT_ENTRIES_DFLT,
   parameter int              GHR_BITS    = GHR_BITS_DFLT,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic [XLEN-1:0] inst_mem_read_addr,
   output logic            inst_mem_read_enable,
   output logic            if_pred_taken,
   output logic [XLEN-1:0] if_pred_target,
   output logic            flush
);

   localparam int              BTB_W  = $clog2(BTB_ENTRIES);
   localparam int              BHT_W  = $clog2(BHT_ENTRIES);
   localparam int              TAG_W  = XLEN - 2 - BTB_W;
   localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

   if (GHR_BITS < 2 || GHR_BITS > BHT_W) begin : g_ghr_check
      $error("if_fetch_btb: GHR_BITS must be in 2..log2(BHT_ENTRIES)");
   end

   logic [XLEN-1:0]  pc_q, pc_d;
   ctr_t             ctr_q [BHT_ENTRIES];
   ctr_t             ctr_d [BHT_ENTRIES];
   logic             btb_hit;
   logic [XLEN-1:0]  btb_target;
   logic [BHT_W-1:0] fetch_bht_idx;
   logic [BHT_W-1:0] ex_bht_idx;
   logic             mispredict;

`ifdef GSHARE_EN
   logic [GHR_BITS-1:0] ghr_q, ghr_d;
   logic [BHT_W-1:0]    ghr_ext;

   always_comb begin
      ghr_ext                = '0;
      ghr_ext[GHR_BITS-1:0]  = ghr_q;
   end

   assign fetch_bht_idx = pc_q[2 +: BHT_W] ^ ghr_ext;
   assign ex_bht_idx    = ex_pc[2 +: BHT_W] ^ ghr_ext;

   // History is only updated at resolve, never speculatively at fetch.
   always_comb begin
      ghr_d = ghr_q;
      if (ex_valid) ghr_d = {ghr_q[GHR_BITS-2:0], ex_taken};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ghr_q <= '0;
      else          ghr_q <= ghr_d;
   end
`else
   assign fetch_bht_idx = pc_q[2 +: BHT_W];
   assign ex_bht_idx    = ex_pc[2 +: BHT_W];
`endif

   if_btb #(
      .XLEN    (XLEN),
      .ENTRIES (BTB_ENTRIES),
      .IDX_W   (BTB_W),
      .TAG_W   (TAG_W)
   ) u_btb (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_idx    (pc_q[2 +: BTB_W]),
      .rd_tag    (pc_q[XLEN-1 -: TAG_W]),
      .rd_hit    (btb_hit),
      .rd_target (btb_target),
      .wr_en     (ex_valid && ex_taken),
      .wr_idx    (ex_pc[2 +: BTB_W]),
      .wr_tag    (ex_pc[XLEN-1 -: TAG_W]),
      .wr_target (ex_target)
   );

   assign if_pred_taken  = btb_hit && ctr_q[fetch_bht_idx][1];
   assign if_pred_target = if_pred_taken ? btb_target : pc_q + PC_INC;

   assign mispredict = reset_n && ex_valid &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target)));
   assign flush      = mispredict;

   assign inst_mem_read_addr   = pc_q;
   assign inst_mem_read_enable = reset_n;

   // Redirect beats stall: the stalled instruction is younger and gets flushed.
   always_comb begin
      pc_d = if_pred_target;
      if (mispredict)  pc_d = ex_taken ? ex_target : ex_pc + PC_INC;
      else if (stall)  pc_d = pc_q;
   end

   always_comb begin
      ctr_d = ctr_q;
      if (ex_valid) ctr_d[ex_bht_idx] = ctr_next(ctr_q[ex_bht_idx], ex_taken);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= RESET_PC;
         for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= WNT;
      end else begin
         pc_q  <= pc_d;
         ctr_q <= ctr_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_btb.sv
//------------------------------------------------------------------------------
// tb_if_fetch_btb : directed vector table plus randomized run against a model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_btb;

   localparam int BTB   = 16;
   localparam int BHT   = 64;
   localparam int GHRB  = 6;
   localparam int NRAND = 3000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic [31:0] inst_mem_read_addr;
   logic        inst_mem_read_enable;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        flush;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch_btb #(
      .XLEN(32), .BTB_ENTRIES(BTB), .BHT_ENTRIES(BHT), .GHR_BITS(GHRB), .RESET_PC(32'h0)
   ) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .stall                (stall),
      .ex_valid             (ex_valid),
      .ex_pc                (ex_pc),
      .ex_taken             (ex_taken),
      .ex_target            (ex_target),
      .ex_pred_taken        (ex_pred_taken),
      .ex_pred_target       (ex_pred_target),
      .inst_mem_read_addr   (inst_mem_read_addr),
      .inst_mem_read_enable (inst_mem_read_enable),
      .if_pred_taken        (if_pred_taken),
      .if_pred_target       (if_pred_target),
      .flush                (flush)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic [31:0] p, input logic t,
                        input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
      stall = s; ex_valid = v; ex_pc = p; ex_taken = t;
      ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
   endtask

   // ---------------- behavioural reference model ----------------
   bit          m_valid [BTB];
   logic [31:0] m_tag   [BTB];
   logic [31:0] m_tgt   [BTB];
   int          m_cnt   [BHT];
   int          m_ghr;
   logic [31:0] m_pc;

   function automatic void model_reset();
      for (int i = 0; i < BTB; i++) m_valid[i] = 1'b0;
      for (int i = 0; i < BHT; i++) m_cnt[i] = 1;
      m_ghr = 0;
      m_pc  = 32'h0;
   endfunction

   function automatic int set_of(input logic [31:0] pc);
      return int'((pc >> 2) % BTB);
   endfunction

   function automatic int ctr_of(input logic [31:0] pc);
`ifdef GSHARE_EN
      return int'(((pc >> 2) ^ 32'(m_ghr)) % BHT);
`else
      return int'((pc >> 2) % BHT);
`endif
   endfunction

   function automatic void predict(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
      int s;
      s   = set_of(pc);
      pt  = m_valid[s] && (m_tag[s] == (pc >> 6)) && (m_cnt[ctr_of(pc)] >= 2);
      tgt = pt ? m_tgt[s] : pc + 32'd4;
   endfunction

   function automatic void model_step(output logic e_flush);
      logic pt;
      logic [31:0] ptgt;
      int c;
      predict(m_pc, pt, ptgt);
      e_flush = ex_valid && ((ex_taken != ex_pred_taken) ||
                             (ex_taken && ex_target != ex_pred_target));
      if (e_flush)    m_pc = ex_taken ? ex_target : ex_pc + 32'd4;
      else if (!stall) m_pc = ptgt;
      if (ex_valid) begin
         c = ctr_of(ex_pc);
         m_cnt[c] = ex_taken ? ((m_cnt[c] == 3) ? 3 : m_cnt[c] + 1)
                             : ((m_cnt[c] == 0) ? 0 : m_cnt[c] - 1);
         if (ex_taken) begin
            m_valid[set_of(ex_pc)] = 1'b1;
            m_tag[set_of(ex_pc)]   = ex_pc >> 6;
            m_tgt[set_of(ex_pc)]   = ex_target;
         end
         m_ghr = ((m_ghr << 1) | int'(ex_taken)) & ((1 << GHRB) - 1);
      end
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        s, v;
      logic [31:0] p;
      logic        t;
      logic [31:0] tg;
      logic        pt;
      logic [31:0] ptg;
      logic [31:0] e_pc;
      logic        e_fl;
      logic        e_pt;
      logic [31:0] e_tgt;
   } vec_t;

   vec_t vec [23];

   function automatic vec_t mk(input logic s, input logic v, input logic [31:0] p, input logic t,
                               input logic [31:0] tg, input logic pt, input logic [31:0] ptg,
                               input logic [31:0] e_pc, input logic e_fl, input logic e_pt,
                               input logic [31:0] e_tgt);
      vec_t r;
      r.s = s; r.v = v; r.p = p; r.t = t; r.tg = tg; r.pt = pt; r.ptg = ptg;
      r.e_pc = e_pc; r.e_fl = e_fl; r.e_pt = e_pt; r.e_tgt = e_tgt;
      return r;
   endfunction

   initial begin
      logic        e_fl;
      logic        e_pt;
      logic [31:0] e_tgt;
      int          pick;

      //           s  v  ex_pc  t  tgt     pt ptgt    | pc     fl pt tgt
      vec[0]  = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h00,  0, 0, 32'h04);
      vec[1]  = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h04,  0, 0, 32'h08);
      vec[2]  = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h08,  0, 0, 32'h0C);
      vec[3]  = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h0C,  0, 0, 32'h10);
      vec[4]  = mk(1, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h10,  0, 0, 32'h14);
      vec[5]  = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h10,  0, 0, 32'h14);
      vec[6]  = mk(0, 1, 32'h10, 1, 32'h80, 0, 32'h14,  32'h14,  1, 0, 32'h18);
      vec[7]  = mk(0, 1, 32'h10, 1, 32'h80, 0, 32'h14,  32'h80,  1, 0, 32'h84);
      vec[8]  = mk(0, 1, 32'h0C, 0, 32'h0,  1, 32'h40,  32'h80,  1, 0, 32'h84);
      vec[9]  = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h10,  0, 1, 32'h80);
      vec[10] = mk(0, 1, 32'h10, 0, 32'h0,  1, 32'h80,  32'h80,  1, 0, 32'h84);
      vec[11] = mk(0, 1, 32'h10, 0, 32'h0,  1, 32'h80,  32'h14,  1, 0, 32'h18);
      vec[12] = mk(0, 1, 32'h10, 0, 32'h0,  1, 32'h80,  32'h14,  1, 0, 32'h18);
      vec[13] = mk(0, 1, 32'h10, 0, 32'h0,  1, 32'h80,  32'h14,  1, 0, 32'h18);
      vec[14] = mk(0, 1, 32'h10, 1, 32'h80, 1, 32'h80,  32'h14,  0, 0, 32'h18);
      vec[15] = mk(0, 1, 32'h0C, 0, 32'h0,  1, 32'h40,  32'h18,  1, 0, 32'h1C);
      vec[16] = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h10,  0, 0, 32'h14);
      vec[17] = mk(1, 1, 32'h10, 1, 32'h80, 0, 32'h14,  32'h14,  1, 0, 32'h18);
      vec[18] = mk(1, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h80,  0, 0, 32'h84);
      vec[19] = mk(0, 1, 32'h50, 1, 32'h200,0, 32'h54,  32'h80,  1, 0, 32'h84);
      vec[20] = mk(0, 1, 32'h0C, 0, 32'h0,  1, 32'h40,  32'h200, 1, 0, 32'h204);
      vec[21] = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h10,  0, 0, 32'h14);
      vec[22] = mk(0, 0, 32'h00, 0, 32'h0,  0, 32'h0,   32'h14,  0, 0, 32'h18);

      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_pc", inst_mem_read_addr, 32'h0);
      chk("reset_pred_taken", 32'(if_pred_taken), 32'h0);
      chk("reset_pred_target", if_pred_target, 32'h4);
      chk("reset_flush", 32'(flush), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

`ifndef GSHARE_EN
      for (int i = 0; i < 23; i++) begin
         drive(vec[i].s, vec[i].v, vec[i].p, vec[i].t, vec[i].tg, vec[i].pt, vec[i].ptg);
         #1;
         chk($sformatf("vec%0d_pc", i), inst_mem_read_addr, vec[i].e_pc);
         chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vec[i].e_fl));
         chk($sformatf("vec%0d_pred_taken", i), 32'(if_pred_taken), 32'(vec[i].e_pt));
         chk($sformatf("vec%0d_pred_target", i), if_pred_target, vec[i].e_tgt);
         @(negedge clk);
      end
`endif

      // Reach pc=0x40, then pull reset mid-cycle with a redirect pending.
      drive(0, 1, 32'h3C, 0, 32'h0, 1, 32'h40);
      @(negedge clk);
      drive(0, 1, 32'h40, 1, 32'h100, 0, 32'h44);
      #1;
      chk("pre_reset_pc", inst_mem_read_addr, 32'h40);
      chk("pre_reset_flush", 32'(flush), 32'h1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_pc", inst_mem_read_addr, 32'h0);
      chk("async_reset_flush", 32'(flush), 32'h0);
      chk("async_reset_pred_taken", 32'(if_pred_taken), 32'h0);
      chk("async_reset_rd_en", 32'(inst_mem_read_enable), 32'h0);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("reset_held_pc", inst_mem_read_addr, 32'h0);
      reset_n = 1'b1;
      model_reset();

      for (int n = 0; n < NRAND; n++) begin
         logic        s, v, t, ppt;
         logic [31:0] p, tg, pptg;
         s  = ($urandom % 4) == 0;
         v  = ($urandom % 2) == 1;
         p  = 32'($urandom_range(0, 47)) << 2;
         t  = ($urandom % 2) == 1;
         tg = 32'($urandom_range(0, 63)) << 2;
         pick = $urandom % 4;
         if (pick != 0) begin
            predict(p, ppt, pptg);
            if (pick == 3) begin
               ppt  = t;
               pptg = tg;
            end
         end else begin
            ppt  = ($urandom % 2) == 1;
            pptg = 32'($urandom_range(0, 63)) << 2;
         end
         drive(s, v, p, t, tg, ppt, pptg);
         #1;
         predict(m_pc, e_pt, e_tgt);
         chk("rand_pc", inst_mem_read_addr, m_pc);
         chk("rand_pred_taken", 32'(if_pred_taken), 32'(e_pt));
         chk("rand_pred_target", if_pred_target, e_tgt);
         chk("rand_rd_en", 32'(inst_mem_read_enable), 32'h1);
         model_step(e_fl);
         chk("rand_flush", 32'(flush), 32'(e_fl));
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
